alu_mdu_controller: RTL and testbench

//  Parametrised ALU/MDU control unit for the EX stage. Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation combinationally.

---
 rtl/alu_mdu_controller.sv | 159 +++++++++++++++
 tb/tb_alu_mdu_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU operation decode and RV32M multi-cycle sequencer.
// Drives an external iterative mul/div datapath; stalls the pipe meanwhile.
module alu_mdu_controller #(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp,
  input  logic            Imm,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            div_by_zero_i,
  input  logic            flush,
  output logic [OP_W-1:0] Operation,
  output logic            md_start,
  output logic [2:0]      md_op,
  output logic            md_kill,
  output logic            md_done,
  output logic            result_sel,
  output logic            stall
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       kill_q, kill_d;
  logic [2:0] op_q, op_d;
  logic [3:0] op4;
  logic       is_m;
  logic       m_req;

  assign is_m  = (ALUOp == 2'b10) && !Imm
              && (Funct7 == 7'b0000001);
  assign m_req = valid_i && is_m;

  // ALU operation decode, purely combinational
  always_comb begin
    op4 = 4'b0000;
    unique case (ALUOp)
      2'b00: op4 = 4'b0010;
      2'b01: begin
        unique case (Funct3[2:1])
          2'b00:   op4 = 4'b1000;
          2'b10:   op4 = 4'b1001;
          2'b11:   op4 = 4'b1010;
          default: op4 = 4'b0000;
        endcase
      end
      2'b10: begin
        if (!is_m) begin
          unique case (Funct3)
            3'b000: op4 = (!Imm && Funct7 == 7'b0100000)
                        ? 4'b0011 : 4'b0010;
            3'b001: op4 = 4'b0110;
            3'b010: op4 = 4'b1001;
            3'b011: op4 = 4'b1010;
            3'b100: op4 = 4'b0100;
            3'b101: begin
              if (Funct7 == 7'b0000000)
                op4 = 4'b0111;
              else if (Funct7 == 7'b0100000)
                op4 = 4'b0101;
              else
                op4 = 4'b0000;
            end
            3'b110: op4 = 4'b0001;
            default: op4 = 4'b0000;
          endcase
        end
      end
      default: op4 = 4'b0000;
    endcase
  end

  // Widen to OP_W with upper bits tied low
  always_comb begin
    Operation      = '0;
    Operation[3:0] = op4;
  end

  // Sequencer next-state and pulse outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    kill_d   = 1'b0;
    op_d     = op_q;
    stall    = 1'b0;
    md_start = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_req && !flush) begin
          stall   = 1'b1;
          state_d = BUSY;
          first_d = 1'b1;
          op_d    = Funct3;
          if (Funct3[2] && div_by_zero_i)
            cnt_d = CNT_W'(1);
          else if (Funct3[2])
            cnt_d = CNT_W'(DIV_LAT);
          else
            cnt_d = CNT_W'(MUL_LAT);
        end
      end
      BUSY: begin
        stall    = 1'b1;
        md_start = first_q;
        if (flush) begin
          state_d = IDLE;
          kill_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        md_done = !flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result_sel = md_done;
  assign md_kill    = kill_q;
  assign md_op      = op_q;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      kill_q  <= 1'b0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      kill_q  <= kill_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Randomized bench for alu_mdu_controller against a
// timestamp-based reference of the M-op sequencing rules.
module tb_alu_mdu_controller;

  localparam int OP_W    = 4;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_i;
  logic [1:0]      ALUOp;
  logic            Imm;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            div_by_zero_i;
  logic            flush;
  logic [OP_W-1:0] Operation;
  logic            md_start;
  logic [2:0]      md_op;
  logic            md_kill;
  logic            md_done;
  logic            result_sel;
  logic            stall;

  int vecs = 0;
  int errs = 0;

  // Reference state: an op in flight is described by the
  // number of cycles elapsed since its request and its latency.
  bit       m_busy = 0;
  int       m_k    = 0;
  int       m_lat  = 0;
  bit       m_kill = 0;
  bit [2:0] m_op   = 0;

  alu_mdu_controller #(
    .OP_W(OP_W),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid_i(valid_i),
    .ALUOp(ALUOp),
    .Imm(Imm),
    .Funct7(Funct7),
    .Funct3(Funct3),
    .div_by_zero_i(div_by_zero_i),
    .flush(flush),
    .Operation(Operation),
    .md_start(md_start),
    .md_op(md_op),
    .md_kill(md_kill),
    .md_done(md_done),
    .result_sel(result_sel),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_op(
    input logic [1:0] a, input logic im,
    input logic [6:0] f7, input logic [2:0] f3);
    if (a == 2'b00) return 4'b0010;
    if (a == 2'b11) return 4'b0000;
    if (a == 2'b01) begin
      if (f3 <= 3'd1) return 4'b1000;
      if (f3 == 3'd4 || f3 == 3'd5) return 4'b1001;
      if (f3 >= 3'd6) return 4'b1010;
      return 4'b0000;
    end
    if (!im && f7 == 7'd1) return 4'b0000;
    case (f3)
      3'd0: return (!im && f7 == 7'h20) ? 4'b0011 : 4'b0010;
      3'd1: return 4'b0110;
      3'd2: return 4'b1001;
      3'd3: return 4'b1010;
      3'd4: return 4'b0100;
      3'd5: begin
        if (f7 == 7'h00) return 4'b0111;
        if (f7 == 7'h20) return 4'b0101;
        return 4'b0000;
      end
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic step(input logic v, input logic [1:0] a,
                      input logic im, input logic [6:0] f7,
                      input logic [2:0] f3, input logic dz,
                      input logic fl, input logic rs);
    bit mreq, e_stall, e_start, e_done;
    @(negedge clk);
    valid_i = v; ALUOp = a; Imm = im; Funct7 = f7;
    Funct3 = f3; div_by_zero_i = dz; flush = fl; reset = rs;
    #1;
    mreq = v && a == 2'b10 && !im && f7 == 7'd1;
    e_stall = 0; e_start = 0; e_done = 0;
    if (!m_busy) e_stall = mreq && !fl;
    else if (m_k <= m_lat) begin
      e_stall = 1;
      e_start = (m_k == 1);
    end else e_done = !fl;
    chk("operation", 32'(Operation), 32'(ref_op(a, im, f7, f3)));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("md_start", 32'(md_start), 32'(e_start));
    chk("md_done", 32'(md_done), 32'(e_done));
    chk("result_sel", 32'(result_sel), 32'(e_done));
    chk("md_kill", 32'(md_kill), 32'(m_kill));
    chk("md_op", 32'(md_op), 32'(m_op));
    @(posedge clk);
    if (rs) begin
      m_busy = 0; m_kill = 0; m_op = 0;
    end else begin
      m_kill = m_busy && m_k <= m_lat && fl;
      if (!m_busy) begin
        if (mreq && !fl) begin
          m_busy = 1; m_k = 1; m_op = f3;
          m_lat = f3[2] ? (dz ? 1 : DIV_LAT) : MUL_LAT;
        end
      end else if (m_k <= m_lat) begin
        if (fl) m_busy = 0;
        else m_k++;
      end else m_busy = 0;
    end
  endtask

  // Present one M-op for n cycles
  task automatic mop(input logic [2:0] f3, input logic dz,
                     input int n);
    for (int i = 0; i < n; i++)
      step(1, 2'b10, 0, 7'd1, f3, dz, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 2'b00, 0, 7'd0, 3'd0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; valid_i = 0; ALUOp = 0; Imm = 0;
    Funct7 = 0; Funct3 = 0; div_by_zero_i = 0; flush = 0;

    // Exhaustive decode sweep while the sequencer sits idle
    for (int a = 0; a < 4; a++)
      for (int im = 0; im < 2; im++)
        for (int f7 = 0; f7 < 128; f7++)
          for (int f3 = 0; f3 < 8; f3++) begin
            ALUOp = 2'(a); Imm = 1'(im);
            Funct7 = 7'(f7); Funct3 = 3'(f3);
            #1;
            chk("decode", 32'(Operation),
                32'(ref_op(2'(a), 1'(im), 7'(f7), 3'(f3))));
          end

    step(0, 2'b00, 0, 7'd0, 3'd0, 0, 0, 1);
    step(0, 2'b00, 0, 7'd0, 3'd0, 0, 0, 1);
    idle(2);

    // MUL, DIVU by zero, DIVU nonzero
    mop(3'b000, 0, MUL_LAT + 2); idle(2);
    mop(3'b101, 1, 3);           idle(2);
    mop(3'b101, 0, DIV_LAT + 2); idle(2);
    // REM then MUL back to back
    mop(3'b110, 0, DIV_LAT + 2);
    mop(3'b000, 0, MUL_LAT + 2); idle(2);
    // Flush at BUSY cycle 5 of DIV
    mop(3'b100, 0, 5);
    step(1, 2'b10, 0, 7'd1, 3'b100, 0, 1, 0);
    idle(3);
    // Flush in DONE
    mop(3'b000, 0, MUL_LAT + 1);
    step(1, 2'b10, 0, 7'd1, 3'b000, 0, 1, 0);
    idle(2);
    // Reset mid-op
    mop(3'b111, 0, 4);
    step(1, 2'b10, 0, 7'd1, 3'b111, 0, 0, 1);
    idle(3);

    // Randomized traffic biased toward M-ops
    for (int i = 0; i < 5000; i++) begin
      logic [6:0] f7;
      logic [1:0] a;
      case ($urandom_range(3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = ($urandom_range(1) == 1) ? 2'b10 : 2'($urandom);
      step(1'($urandom_range(3) != 0), a,
           1'($urandom_range(3) == 0), f7, 3'($urandom),
           1'($urandom_range(7) == 0),
           1'($urandom_range(63) == 0),
           1'($urandom_range(255) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
